// File: rtl/tile_classifier_if.sv
// Pixel stream and result handshake between the frame-buffer scanner,
// the tile classifier and the tile-map writer.
interface tile_classifier_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [2:0]  pix_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  tile_type;
    logic [1:0]  rotation;
    logic        match;
    logic [15:0] match_mask;

    modport master (
        output pix_valid, pix_in, out_ready,
        input  pix_ready, out_valid, tile_type, rotation, match, match_mask
    );

    modport slave (
        input  pix_valid, pix_in, out_ready,
        output pix_ready, out_valid, tile_type, rotation, match, match_mask
    );
endinterface

// File: rtl/tile_classifier.sv
// Streaming 8x8 tile recogniser: narrows 16 (type, rotation) candidates pixel by
// pixel and reports the lowest-index survivor once the 64th pixel is accepted.
module tile_classifier (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    tile_classifier_if.slave bus
);
    typedef enum logic {S_COLLECT = 1'b0, S_RESULT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [15:0] r_mask;
    logic [1:0]  r_type;
    logic [1:0]  r_rot;
    logic        r_match;
    logic [15:0] r_match_mask;

    logic        w_accept;
    logic        w_last;
    logic        w_lit;
    logic        w_illegal;
    logic [2:0]  w_x;
    logic [2:0]  w_y;
    logic [15:0] w_exp;
    logic [15:0] w_mask_upd;
    logic [3:0]  w_first;

    function automatic logic [7:0] row_bits(input logic [1:0] ty, input logic [2:0] row);
        logic [7:0] bits;
        bits = 8'h00;
        case (ty)
            2'd1: bits = 8'b0001_0000;
            2'd2: begin
                if (row == 3'd3)      bits = 8'b0000_0111;
                else if (row == 3'd4) bits = 8'b0000_1000;
                else if (row >= 3'd5) bits = 8'b0001_0000;
            end
            2'd3: begin
                if (row == 3'd4)      bits = 8'b0000_0011;
                else if (row == 3'd5) bits = 8'b0000_0100;
                else if (row >= 3'd6) bits = 8'b0000_1000;
            end
            default: bits = 8'h00;
        endcase
        return bits;
    endfunction

    // Rotation = optional transpose followed by optional flips of each axis.
    function automatic logic e_bit(input logic [1:0] ty, input logic [1:0] rot,
                                   input logic [2:0] y, input logic [2:0] x);
        logic       t;
        logic       fy;
        logic       fx;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] xp;
        logic [2:0] yp;
        logic [7:0] row;
        t   = rot[0];
        fy  = rot[1];
        fx  = (rot == 2'd1) || (rot == 2'd2);
        a   = t ? x : y;
        b   = t ? y : x;
        xp  = fx ? ~a : a;
        yp  = fy ? b : ~b;
        row = row_bits(ty, yp);
        return row[~xp];
    endfunction

    assign w_x       = r_cnt[2:0];
    assign w_y       = r_cnt[5:3];
    assign w_last    = (r_cnt == 6'd63);
    assign w_accept  = bus.pix_valid && (r_state == S_COLLECT);
    assign w_lit     = (bus.pix_in == 3'd4);
    assign w_illegal = (bus.pix_in != 3'd4) && (bus.pix_in != 3'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi = gi + 1) begin : g_cand
            localparam logic [1:0] TY  = 2'(gi / 4);
            localparam logic [1:0] ROT = 2'(gi % 4);
            assign w_exp[gi] = e_bit(TY, ROT, w_y, w_x);
        end
    endgenerate

    always_comb begin
        w_mask_upd = w_illegal ? 16'h0000 : (r_mask & ~(w_exp ^ {16{w_lit}}));
    end

    // Scanning downwards leaves the lowest set index; stays 0 when nothing matched.
    always_comb begin
        w_first = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (w_mask_upd[k]) w_first = 4'(k);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_COLLECT;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (w_accept && w_last) w_state_next = S_RESULT;
                S_RESULT:  if (bus.out_ready)      w_state_next = S_COLLECT;
                default:   w_state_next = S_COLLECT;
            endcase
        end
    end

    always_comb begin
        bus.pix_ready = (r_state == S_COLLECT);
        bus.out_valid = (r_state == S_RESULT);
    end

    // Counter and mask are re-armed on the last pixel so RESULT can return straight to COLLECT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= 6'd0;
            r_mask       <= 16'hFFFF;
            r_type       <= 2'd0;
            r_rot        <= 2'd0;
            r_match      <= 1'b0;
            r_match_mask <= 16'h0000;
        end else if (clear) begin
            r_cnt  <= 6'd0;
            r_mask <= 16'hFFFF;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt           <= 6'd0;
                r_mask          <= 16'hFFFF;
                r_match_mask    <= w_mask_upd;
                r_match         <= |w_mask_upd;
                {r_type, r_rot} <= w_first;
            end else begin
                r_cnt  <= r_cnt + 6'd1;
                r_mask <= w_mask_upd;
            end
        end
    end

    assign bus.tile_type  = r_type;
    assign bus.rotation   = r_rot;
    assign bus.match      = r_match;
    assign bus.match_mask = r_match_mask;
endmodule

// File: tb/tb_tile_classifier.sv
// Scoreboard bench for tile_classifier: whole-tile reference classification against
// 16 precomputed candidate bitmaps, with a decoupled result monitor.
module tb_tile_classifier;
    typedef logic [2:0] tile_t [64];
    typedef struct packed {
        logic [15:0] mask;
        logic [1:0]  ty;
        logic [1:0]  rot;
        logic        m;
    } res_t;

    logic clk;
    logic reset_n;
    logic clear;
    tile_classifier_if bus();

    tile_classifier u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    res_t exp_q[$];
    res_t last_res = '0;
    int   gap_pct = 0;
    int   hold_cfg = -1;
    bit   freeze = 1'b0;

    int rows [4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                        '{16, 16, 16, 16, 16, 16, 16, 16},
                        '{0, 0, 0, 7, 8, 16, 16, 16},
                        '{0, 0, 0, 0, 3, 4, 8, 8}};
    bit bm [16][64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    function automatic bit e_ref(int ty, int rot, int y, int x);
        int a, b, xp, yp;
        bit t, fy, fx;
        t  = (rot % 2) == 1;
        fy = rot >= 2;
        fx = (rot == 1) || (rot == 2);
        a  = t ? x : y;
        b  = t ? y : x;
        xp = fx ? 7 - a : a;
        yp = fy ? b : 7 - b;
        return ((rows[ty][yp] >> (7 - xp)) & 1) == 1;
    endfunction

    function automatic res_t classify(input tile_t px);
        res_t r;
        bit   ok;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            ok = 1'b1;
            for (int i = 0; i < 64; i++) begin
                if (px[i] != 3'd4 && px[i] != 3'd0) ok = 1'b0;
                else if ((px[i] == 3'd4) != bm[k][i]) ok = 1'b0;
            end
            r.mask[k] = ok;
        end
        r.m = |r.mask;
        for (int k = 0; k < 16; k++) begin
            if (r.mask[k]) begin
                {r.ty, r.rot} = 4'(k);
                break;
            end
        end
        return r;
    endfunction

    function automatic tile_t cand_tile(int k);
        tile_t px;
        for (int i = 0; i < 64; i++) px[i] = bm[k][i] ? 3'd4 : 3'd0;
        return px;
    endfunction

    // Streams a tile; clear_at >= 0 aborts with clear once that many pixels are in.
    task automatic send_tile(input tile_t px, input int clear_at);
        int idx = 0;
        int cyc = 0;
        while (idx < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                chk("send_timeout", 32'(idx), 32'd64);
                bus.pix_valid = 1'b0;
                return;
            end
            if (!bus.pix_ready) begin
                bus.pix_valid = 1'($urandom_range(0, 1));
                bus.pix_in    = 3'($urandom);
                continue;
            end
            if (idx == clear_at) begin
                clear = 1'b1;
                bus.pix_valid = 1'b1;
                bus.pix_in    = px[idx];
                @(negedge clk);
                clear = 1'b0;
                bus.pix_valid = 1'b0;
                chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
                chk("clear_pix_ready", 32'(bus.pix_ready), 32'd1);
                chk("clear_keep_mask", 32'(bus.match_mask), 32'(last_res.mask));
                return;
            end
            if ($urandom_range(0, 99) < gap_pct) begin
                bus.pix_valid = 1'b0;
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_in    = px[idx];
                idx++;
                if (idx == 64) exp_q.push_back(classify(px));
            end
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) return;
        end
        chk("idle_timeout_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Result monitor: pops the scoreboard on each new result and checks it every held cycle.
    initial begin : monitor
        bit   in_res = 1'b0;
        bit   have_exp = 1'b0;
        bit   rel_chk = 1'b0;
        int   hold = 0;
        res_t cur = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_res = 1'b0;
                rel_chk = 1'b0;
                bus.out_ready = 1'b0;
                continue;
            end
            if (rel_chk) begin
                chk("release_out_valid", 32'(bus.out_valid), 32'd0);
                chk("release_pix_ready", 32'(bus.pix_ready), 32'd1);
                rel_chk = 1'b0;
            end
            if (bus.out_valid) begin
                if (!in_res) begin
                    in_res = 1'b1;
                    if (exp_q.size() == 0) begin
                        have_exp = 1'b0;
                        chk("unexpected_result", 32'(bus.out_valid), 32'd0);
                    end else begin
                        have_exp = 1'b1;
                        cur = exp_q.pop_front();
                        last_res = cur;
                        $display("result: mask=%04h type=%0d rot=%0d match=%0d (want mask=%04h type=%0d rot=%0d match=%0d)",
                                 bus.match_mask, bus.tile_type, bus.rotation, bus.match,
                                 cur.mask, cur.ty, cur.rot, cur.m);
                    end
                    hold = (hold_cfg >= 0) ? hold_cfg : int'($urandom_range(0, 4));
                end
                if (have_exp) begin
                    chk("match_mask", 32'(bus.match_mask), 32'(cur.mask));
                    chk("tile_type",  32'(bus.tile_type),  32'(cur.ty));
                    chk("rotation",   32'(bus.rotation),   32'(cur.rot));
                    chk("match",      32'(bus.match),      32'(cur.m));
                end
                chk("result_pix_ready", 32'(bus.pix_ready), 32'd0);
                if (freeze) begin
                    bus.out_ready = 1'b0;
                end else if (hold == 0) begin
                    bus.out_ready = 1'b1;
                    rel_chk = 1'b1;
                end else begin
                    hold--;
                end
            end else begin
                in_res = 1'b0;
                bus.out_ready = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin : stimulus
        tile_t px;
        int    k;
        for (int c = 0; c < 16; c++)
            for (int i = 0; i < 64; i++)
                bm[c][i] = e_ref(c / 4, c % 4, i / 8, i % 8);

        reset_n = 1'b0;
        clear = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in = 3'd0;
        #3;
        chk("reset_pix_ready",  32'(bus.pix_ready),  32'd1);
        chk("reset_out_valid",  32'(bus.out_valid),  32'd0);
        chk("reset_tile_type",  32'(bus.tile_type),  32'd0);
        chk("reset_rotation",   32'(bus.rotation),   32'd0);
        chk("reset_match",      32'(bus.match),      32'd0);
        chk("reset_match_mask", 32'(bus.match_mask), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Empty tile, then horizontal and vertical straight lines.
        for (int i = 0; i < 64; i++) px[i] = 3'd0;
        send_tile(px, -1);
        for (int i = 0; i < 64; i++) px[i] = (i / 8 == 3) ? 3'd4 : 3'd0;
        send_tile(px, -1);
        for (int i = 0; i < 64; i++) px[i] = (i % 8 == 3) ? 3'd4 : 3'd0;
        send_tile(px, -1);
        wait_idle();

        // Every candidate bitmap, with the result held for five cycles.
        hold_cfg = 5;
        for (int c = 0; c < 16; c++) send_tile(cand_tile(c), -1);
        wait_idle();
        hold_cfg = -1;

        // Illegal colour inside an otherwise matching tile.
        px = cand_tile(4);
        px[20] = 3'd2;
        send_tile(px, -1);

        // Abort after 30 pixels, then a clean corner tile; then clear on pixel 63.
        send_tile(cand_tile(5), 30);
        send_tile(cand_tile(8), -1);
        wait_idle();
        send_tile(cand_tile(12), 63);
        send_tile(cand_tile(13), -1);
        wait_idle();

        // Reset pulsed while a result is pending.
        gap_pct = 30;
        freeze = 1'b1;
        send_tile(cand_tile(9), -1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("async_rst_pix_ready",  32'(bus.pix_ready),  32'd1);
        chk("async_rst_match_mask", 32'(bus.match_mask), 32'd0);
        chk("async_rst_match",      32'(bus.match),      32'd0);
        @(negedge clk);
        exp_q.delete();
        last_res = '0;
        reset_n = 1'b1;
        freeze = 1'b0;

        // Random tiles: candidate bitmaps with occasional flipped or illegal pixels.
        for (int n = 0; n < 14; n++) begin
            k = int'($urandom_range(0, 15));
            px = cand_tile(k);
            case ($urandom_range(0, 3))
                0: px[$urandom_range(0, 63)] ^= 3'd4;
                1: px[$urandom_range(0, 63)] = 3'($urandom_range(1, 3));
                2: for (int i = 0; i < 64; i++) px[i] = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'd0;
                default: ;
            endcase
            send_tile(px, -1);
        end
        wait_idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
